// File: rtl/daisy_rr_arbiter.sv
// daisy_rr_arbiter: round-robin arbiter built as a circular daisy chain.
// The search starts at a rotating pointer, and the registered one-hot
// grant is held until the grantee releases it. Every release is followed
// by one idle cycle before the next grant is issued.
//
// Optional feature: define ARB_TIMEOUT_EN to preempt a grant after
// MAXHOLD BUSY cycles. tout pulses on the edge that performs that release.
// When ARB_TIMEOUT_EN is not defined, no hold counter is built, tout is
// tied low and MAXHOLD has no effect.
//
// state | meaning
// IDLE  | no grant; search the requests starting at ptr
// BUSY  | grant held; wait for done, a dropped request or a timeout

module daisy_rr_arbiter #(
    parameter int N       = 8,
    parameter int MAXHOLD = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [0:N-1]         r,
    input  logic                 done,
    output logic [0:N-1]         g,
    output logic [$clog2(N)-1:0] gid,
    output logic                 gv,
    output logic                 tout
);

    localparam int           W      = $clog2(N);
    localparam int           WP     = W + 1;
    localparam logic [WP-1:0] W_N    = WP'(N);
    localparam logic [W-1:0]  W_LAST = W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_ptr;
    logic [W-1:0]   w_ptr_nxt;
    logic [W-1:0]   r_gid;
    logic [W-1:0]   w_gid_nxt;
    logic [0:N-1]   r_g;
    logic [0:N-1]   w_g_nxt;
    logic [W-1:0]   w_win;
    logic [WP-1:0]  w_idx;
    logic           w_found;
    logic           w_release;
    logic           w_timeout;

    generate
        if (N < 2 || N > 32) begin : g_bad_n
            $error("daisy_rr_arbiter: N must be in 2..32");
        end
        if (MAXHOLD < 1 || MAXHOLD > 255) begin : g_bad_maxhold
            $error("daisy_rr_arbiter: MAXHOLD must be in 1..255");
        end
    endgenerate

    // Circular priority search: first set request at ptr, ptr+1, ..., wrapping at N
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, r_ptr} + WP'(i);
            if (w_idx >= W_N) begin
                w_idx = w_idx - W_N;
            end
            if (!w_found && r[w_idx[W-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[W-1:0];
            end
        end
    end

    // Only meaningful in BUSY; the request check looks at the current grantee
    assign w_release = done || !r[r_gid] || w_timeout;

    // State, pointer and grant registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_g     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gid   <= w_gid_nxt;
            r_g     <= w_g_nxt;
        end
    end

    // Next-state logic: grant from IDLE, release from BUSY (release always lands in IDLE)
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gid_nxt   = r_gid;
        w_g_nxt     = r_g;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt    = BUSY;
                    w_gid_nxt      = w_win;
                    w_g_nxt        = '0;
                    w_g_nxt[w_win] = 1'b1;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_state_nxt = IDLE;
                    w_g_nxt     = '0;
                    w_ptr_nxt   = (r_gid == W_LAST) ? '0 : r_gid + W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_g_nxt     = '0;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] W_MAXHOLD = 8'(MAXHOLD);

    logic [7:0] r_hold;
    logic       r_tout;

    // Hold counter: zero while idle, so it starts at 0 on BUSY entry; saturates at MAXHOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_state == IDLE) begin
            r_hold <= '0;
        end else if (r_hold != W_MAXHOLD) begin
            r_hold <= r_hold + 8'd1;
        end
    end

    // The counter reaches MAXHOLD on the edge that ends the MAXHOLD-th BUSY cycle
    assign w_timeout = (r_state == BUSY) && (r_hold == W_MAXHOLD - 8'd1);

    // Timeout pulse, raised on the same edge that clears the grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tout <= 1'b0;
        end else begin
            r_tout <= w_timeout;
        end
    end

    assign tout = r_tout;
`else
    assign w_timeout = 1'b0;
    assign tout      = 1'b0;
`endif

    assign g   = r_g;
    assign gid = r_gid;
    assign gv  = (r_state == BUSY);

endmodule

// File: doc/daisy_rr_arbiter.md
DAISY_RR_ARBITER -- requirements
Module: daisy_rr_arbiter

Interface
REQ-001 Parameter N SHALL default to 8; number of requesters, valid range 2..32.
REQ-002 Parameter MAXHOLD SHALL default to 15; maximum cycles a grant is held when the timeout feature is compiled in, range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 r  input  [0:N-1]  SHALL carry request lines; bit 0 is index 0 (MSB position).
REQ-006 done  input  1  SHALL be the release strobe from the current grantee.
REQ-007 g  output  [0:N-1]  SHALL be the registered one-hot grant, or all-zero.
REQ-008 gid  output  [clog2(N)-1:0]  SHALL be the index of the granted bit; valid only while gv=1.
REQ-009 gv  output  1  SHALL be high exactly when g is non-zero.
REQ-010 tout  output  1  SHALL be a one-cycle pulse marking a timeout release.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-012 In IDLE with r==0, the block SHALL remain in IDLE with g=0.
REQ-013 In IDLE with r!=0, the winner SHALL be the first set bit scanning indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (circular daisy chain).
REQ-014 The winner's grant SHALL appear on g one cycle after the sampling edge (latency 1), with the state moving to BUSY.
REQ-015 In BUSY, g, gid and gv SHALL hold constant regardless of changes on other r bits.
REQ-016 BUSY SHALL release on any of: done=1; r[gid]=0; the hold counter reaching MAXHOLD (timeout feature only).
REQ-017 On release, the next edge SHALL clear g, set the state to IDLE and set ptr=(gid+1) mod N.
REQ-018 A mandatory dead cycle SHALL separate consecutive grants; back-to-back grants never occur.
REQ-019 The hold counter SHALL clear on entry to BUSY and increment once per BUSY cycle, saturating at MAXHOLD.
REQ-020 If done and the timeout coincide, release SHALL occur once and tout SHALL still pulse.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 ptr wrap-around SHALL follow: gid=N-1 releasing gives ptr=0.
REQ-023 g SHALL never have more than one bit set in any cycle.

Reset
REQ-024 While rst=1: state=IDLE, ptr=0, hold counter=0, g=0, gid=0, gv=0, tout=0, applied immediately without waiting for a clock edge.
REQ-025 Reset asserted mid-grant SHALL drop g asynchronously; after deassertion, arbitration SHALL restart from ptr=0.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN SHALL control preemption.
REQ-027 With ARB_TIMEOUT_EN defined: the hold counter and MAXHOLD release are present, and tout pulses on timeout release.
REQ-028 Without ARB_TIMEOUT_EN: no hold counter is synthesized, grants persist until done or request drop, tout is tied 0, and MAXHOLD is ignored.

Verification (N=8, MAXHOLD=4, ARB_TIMEOUT_EN defined unless stated)
REQ-029 Reset, then r=8'b0010_0100 -> next edge g=0010_0000, gid=2, gv=1; hold r and pulse done -> g=0, then g=0000_0100, gid=5.
REQ-030 Set r=all-ones and pulse done each grant -> gid sequence 0,1,2,...,7,0 with one idle cycle between grants.
REQ-031 Grant on gid=3 with r[3] held and no done -> g cleared after 4 BUSY cycles, tout=1 for one cycle, next winner searched from index 4.
REQ-032 Same stimulus without ARB_TIMEOUT_EN -> grant held 20+ cycles, tout stays 0.
REQ-033 Grant on gid=6, then drop r[6] -> release next edge, ptr=7; then r=1000_0001 -> gid=7.
REQ-034 Assert rst mid-grant, asynchronously between edges -> g=0 before the next clock edge; after release with r=0100_0001 -> gid=1.
